hrange_accum: RTL and testbench

//   Downstream consumer of the hrange generator: a generator implementing
//   "total=0; for i in hrange(base,limit,step): total+=i; yield total, i".

---
 rtl/hrange_accum_if.sv | 41 ++++
 rtl/hrange_accum.sv | 113 +++++++++++
 tb/tb_hrange_accum.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hrange_accum_if.sv
// hrange_accum_if: groups every handshake/data signal around hrange_accum.
//   Caller side : _start, base, limit, step  -> accumulator
//                 _0, _1, _ready, _valid     <- accumulator
//   hrange side : hr_start, hr_base, hr_limit, hr_step <- accumulator
//                 hr_0, hr_valid, hr_ready             -> accumulator
// Modports:
//   slave  - the accumulator itself
//   master - whoever drives the caller inputs and plays the hrange instance
// Handshake semantics: _start is a one-cycle request honoured only while
// _ready is high; _valid is a one-cycle pulse marking a new (_0,_1) pair and
// cannot be back-pressured; hr_valid/hr_ready follow the same rules one level
// down.
interface hrange_accum_if #(
  parameter int WIDTH = 32
);
  logic                    _start;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic signed [WIDTH-1:0] _0;
  logic signed [WIDTH-1:0] _1;
  logic                    _ready;
  logic                    _valid;
  logic                    hr_start;
  logic signed [WIDTH-1:0] hr_base;
  logic signed [WIDTH-1:0] hr_limit;
  logic signed [WIDTH-1:0] hr_step;
  logic signed [WIDTH-1:0] hr_0;
  logic                    hr_valid;
  logic                    hr_ready;

  modport slave (
    input  _start, base, limit, step, hr_0, hr_valid, hr_ready,
    output _0, _1, _ready, _valid, hr_start, hr_base, hr_limit, hr_step
  );

  modport master (
    output _start, base, limit, step, hr_0, hr_valid, hr_ready,
    input  _0, _1, _ready, _valid, hr_start, hr_base, hr_limit, hr_step
  );
endinterface

// File: rtl/hrange_accum.sv
// hrange_accum: running-sum consumer of one hrange generator.
//   total = 0; for i in hrange(base, limit, step): total += i; yield total, i
// Ports:
//   _clock       rising-edge clock
//   _reset       asynchronous active-high reset (shared with the hrange)
//   bus          hrange_accum_if.slave (caller request/yield + hrange link)
//   o_dbg_state  current FSM state (IDLE=0, LAUNCH=1, ARM=2, RUN=3)
// All outputs are registered. A yield from hrange in cycle N appears on
// _0/_1 with _valid in cycle N+1; _0/_1 hold their value between pulses.
module hrange_accum #(
  parameter int WIDTH = 32
) (
  input  logic                _clock,
  input  logic                _reset,
  hrange_accum_if.slave       bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ARM    = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_valid;
  logic                    r_hr_start;
  logic signed [WIDTH-1:0] r_total;
  logic signed [WIDTH-1:0] r_0;
  logic signed [WIDTH-1:0] r_1;
  logic signed [WIDTH-1:0] r_hr_base;
  logic signed [WIDTH-1:0] r_hr_limit;
  logic signed [WIDTH-1:0] r_hr_step;

  // Two's-complement add, wraps silently modulo 2^WIDTH.
  logic signed [WIDTH-1:0] w_sum;
  assign w_sum = r_total + bus.hr_0;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_hr_start <= 1'b0;
      r_total    <= '0;
      r_0        <= '0;
      r_1        <= '0;
      r_hr_base  <= '0;
      r_hr_limit <= '0;
      r_hr_step  <= '0;
    end else begin
      // Pulses default low; only the cycle that sets them raises them.
      r_valid    <= 1'b0;
      r_hr_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus._start) begin
            r_hr_base  <= bus.base;
            r_hr_limit <= bus.limit;
            r_hr_step  <= bus.step;
            r_total    <= '0;
            r_ready    <= 1'b0;
            r_hr_start <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_ARM;
        end
        S_ARM: begin
          // hr_ready may still be the idle level from before the launch, so
          // it is not trusted here; a yield in this cycle is still real.
          if (bus.hr_valid) begin
            r_total <= w_sum;
            r_0     <= w_sum;
            r_1     <= bus.hr_0;
            r_valid <= 1'b1;
          end
          r_state <= S_RUN;
        end
        S_RUN: begin
          // A yield arriving together with hr_ready is still emitted.
          if (bus.hr_valid) begin
            r_total <= w_sum;
            r_0     <= w_sum;
            r_1     <= bus.hr_0;
            r_valid <= 1'b1;
          end
          if (bus.hr_ready) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus._0       = r_0;
  assign bus._1       = r_1;
  assign bus._ready   = r_ready;
  assign bus._valid   = r_valid;
  assign bus.hr_start = r_hr_start;
  assign bus.hr_base  = r_hr_base;
  assign bus.hr_limit = r_hr_limit;
  assign bus.hr_step  = r_hr_step;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_hrange_accum.sv
module tb_hrange_accum;

  localparam int W = 32;

  typedef struct {
    int base;
    int limit;
    int step;
    bit both_last;   // last yield arrives together with hr_ready
    bit first_gap;   // idle cycle (with stale hr_ready) before first yield
    bit gap_en;      // random idle cycles between yields
    int exp_n;       // number of _valid pulses
    int exp_total;   // _0 after the run
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hrange_accum_if #(.WIDTH(W)) bus ();
  hrange_accum_if #(.WIDTH(8)) bus8 ();
  logic [1:0] dbg;
  logic [1:0] dbg8;

  hrange_accum #(.WIDTH(W)) dut (
    ._clock     (clk),
    ._reset     (rst),
    .bus        (bus),
    .o_dbg_state(dbg)
  );

  hrange_accum #(.WIDTH(8)) dut8 (
    ._clock     (clk),
    ._reset     (rst),
    .bus        (bus8),
    .o_dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {total, value}
  int          n_checks = 0;
  int          n_fail   = 0;
  int          yields   = 0;
  int          cyc      = 0;
  logic [31:0] last_0   = '0;
  logic [31:0] last_1   = '0;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle and compare the 32-bit DUT's yield outputs.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    cyc++;
    if (bus._valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus._valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("yield_total", bus._0, e[63:32]);
        check("yield_value", bus._1, e[31:0]);
        last_0 = e[63:32];
        last_1 = e[31:0];
        yields++;
      end
    end else begin
      check("hold_0", bus._0, last_0);
      check("hold_1", bus._1, last_1);
    end
  endtask

  // One cycle of the hrange side of the 32-bit DUT.
  task automatic drive(input bit v, input int d, input bit r);
    bus.hr_valid = v;
    bus.hr_0     = d;
    bus.hr_ready = r;
    tick();
  endtask

  task automatic do_run(input vec_t t);
    int     vals[$];
    longint v;
    logic [31:0] tot;
    bit     stale;
    int     gap;
    int     waited;
    int     c0;
    tot = '0;
    v = t.base;
    while ((t.step > 0) ? (v < t.limit) : (v > t.limit)) begin
      tot = tot + v[31:0];
      vals.push_back(int'(v[31:0]));
      exp_q.push_back({tot, v[31:0]});
      v = v + t.step;
    end
    check("start_ready", 32'(bus._ready), 32'd1);
    yields = 0;
    c0 = cyc;
    bus._start = 1'b1;
    bus.base   = t.base;
    bus.limit  = t.limit;
    bus.step   = t.step;
    tick();
    bus._start = 1'b0;
    check("hr_start_pulse", 32'(bus.hr_start), 32'd1);
    check("hr_base", bus.hr_base, t.base);
    check("hr_limit", bus.hr_limit, t.limit);
    check("hr_step", bus.hr_step, t.step);
    check("busy", 32'(bus._ready), 32'd0);
    tick();
    check("hr_start_clear", 32'(bus.hr_start), 32'd0);
    stale = 1'b1;
    if (t.first_gap) begin
      drive(1'b0, 0, 1'b1);
      stale = 1'b0;
    end
    for (int i = 0; i < vals.size(); i++) begin
      gap = t.gap_en ? int'($urandom_range(0, 1)) : 0;
      repeat (gap) begin
        drive(1'b0, 0, stale);
        stale = 1'b0;
      end
      drive(1'b1, vals[i], ((i == vals.size() - 1) && t.both_last) || stale);
      stale = 1'b0;
    end
    if (!(vals.size() > 0 && t.both_last)) drive(1'b0, 0, 1'b1);
    bus.hr_valid = 1'b0;
    bus.hr_ready = 1'b1;
    waited = 0;
    while (!bus._ready && waited < 8) begin
      tick();
      waited++;
    end
    check("run_done", 32'(bus._ready), 32'd1);
    check("yield_count", yields, t.exp_n);
    check("final_total", bus._0, t.exp_total);
    check("queue_drained", exp_q.size(), 0);
    if (vals.size() == 0) check("empty_latency_ok", 32'((cyc - c0) <= 4), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 10, 2, 1'b0, 1'b0, 1'b0, 5, 20};
    vecs[1] = '{10, 0, -3, 1'b1, 1'b0, 1'b1, 4, 22};
    vecs[2] = '{5, 5, 1, 1'b0, 1'b0, 1'b0, 0, 22};
    vecs[3] = '{-5, 5, 3, 1'b0, 1'b1, 1'b1, 4, -2};
    vecs[4] = '{0, -10, -4, 1'b1, 1'b0, 1'b0, 3, -12};
    vecs[5] = '{7, 8, 1, 1'b1, 1'b0, 1'b0, 1, 7};
    vecs[6] = '{32'h7FFF_FFF0, 32'h7FFF_FFFF, 8, 1'b0, 1'b0, 1'b1, 2, -24};

    rst = 1'b1;
    bus._start = 1'b0; bus.base = '0; bus.limit = '0; bus.step = '0;
    bus.hr_0 = '0; bus.hr_valid = 1'b0; bus.hr_ready = 1'b1;
    bus8._start = 1'b0; bus8.base = '0; bus8.limit = '0; bus8.step = '0;
    bus8.hr_0 = '0; bus8.hr_valid = 1'b0; bus8.hr_ready = 1'b1;

    @(negedge clk);
    check("rst_ready", 32'(bus._ready), 32'd1);
    check("rst_valid", 32'(bus._valid), 32'd0);
    check("rst_0", bus._0, 32'd0);
    check("rst_1", bus._1, 32'd0);
    check("rst_hr_start", 32'(bus.hr_start), 32'd0);
    check("rst_hr_limit", bus.hr_limit, 32'd0);
    check("rst_state", 32'(dbg), 32'd0);
    check("rst8_ready", 32'(bus8._ready), 32'd1);
    rst = 1'b0;
    tick();

    // Table: each run starts on the first cycle _ready is high again.
    for (int k = 0; k < 7; k++) do_run(vecs[k]);

    // Mid-run _start is ignored, then reset aborts after the 2nd yield.
    exp_q.push_back({32'd0, 32'd0});
    exp_q.push_back({32'd2, 32'd2});
    bus._start = 1'b1; bus.base = 0; bus.limit = 10; bus.step = 2;
    tick();
    bus._start = 1'b0;
    tick();
    drive(1'b1, 0, 1'b1);
    bus._start = 1'b1; bus.base = 100; bus.limit = 200; bus.step = 1;
    drive(1'b1, 2, 1'b0);
    bus._start = 1'b0;
    check("ign_hr_base", bus.hr_base, 32'd0);
    check("ign_hr_limit", bus.hr_limit, 32'd10);
    check("ign_hr_step", bus.hr_step, 32'd2);
    check("ign_busy", 32'(bus._ready), 32'd0);
    check("ign_total", bus._0, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus._ready), 32'd1);
    check("abort_valid", 32'(bus._valid), 32'd0);
    check("abort_0", bus._0, 32'd0);
    check("abort_1", bus._1, 32'd0);
    check("abort_state", 32'(dbg), 32'd0);
    check("abort_queue", exp_q.size(), 0);
    last_0 = '0;
    last_1 = '0;
    bus.hr_valid = 1'b0;
    bus.hr_ready = 1'b1;
    tick();
    rst = 1'b0;
    do_run(vecs[0]);

    // 8-bit instance: running total wraps 60 + 80 -> -116.
    bus8._start = 1'b1; bus8.base = 8'sd60; bus8.limit = 8'sd100; bus8.step = 8'sd20;
    tick();
    bus8._start = 1'b0;
    check("w8_hr_start", 32'(bus8.hr_start), 32'd1);
    tick();
    bus8.hr_valid = 1'b1; bus8.hr_0 = 8'sd60; bus8.hr_ready = 1'b0;
    tick();
    check("w8_valid1", 32'(bus8._valid), 32'd1);
    check("w8_total1", bus8._0, 32'd60);
    check("w8_value1", bus8._1, 32'd60);
    bus8.hr_0 = 8'sd80;
    tick();
    check("w8_valid2", 32'(bus8._valid), 32'd1);
    check("w8_total2", bus8._0, -116);
    check("w8_value2", bus8._1, 32'd80);
    bus8.hr_valid = 1'b0; bus8.hr_ready = 1'b1;
    tick();
    tick();
    check("w8_ready", 32'(bus8._ready), 32'd1);
    check("w8_valid_low", 32'(bus8._valid), 32'd0);
    check("w8_hold", bus8._0, -116);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
